// File: rtl/ibex_pkg.sv
// ibex_pkg: shared definitions for the multi-port register file.
//   rf_wipe_state_e  - state encoding of the secure-wipe controller
//   RfMaxReadPorts   - upper bound on NumReadPorts
//   RfMaxWritePorts  - upper bound on NumWritePorts
package ibex_pkg;

   typedef enum logic {
      RfWipeReady  = 1'b0,
      RfWipeActive = 1'b1
   } rf_wipe_state_e;

   localparam int unsigned RfMaxReadPorts  = 4;
   localparam int unsigned RfMaxWritePorts = 2;

endpackage

// File: rtl/ibex_register_file_wipe_ctrl.sv
// ibex_register_file_wipe_ctrl: sequencer for the secure wipe.
// Walks a counter from 1 up to the last register, requesting one register
// write per cycle, then returns to ready. Register 0 has no storage and is
// never visited.
// Ports:
//   clk_i      in   clock
//   rst_ni     in   synchronous active-low reset
//   wipe_req_i in   start request (ignored while a wipe is running)
//   busy_o     out  wipe in progress (registered state decode)
//   wipe_we    out  write strobe for the register at wipe_addr
//   wipe_addr  out  register currently being overwritten
module ibex_register_file_wipe_ctrl
   import ibex_pkg::*;
#(
   parameter int unsigned AddrWidth = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 wipe_req_i,
   output logic                 busy_o,
   output logic                 wipe_we,
   output logic [AddrWidth-1:0] wipe_addr
);

   localparam logic [AddrWidth-1:0] FirstAddr = AddrWidth'(1);
   localparam logic [AddrWidth-1:0] LastAddr  = {AddrWidth{1'b1}};

   rf_wipe_state_e       state_q, state_d;
   logic [AddrWidth-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= RfWipeReady;
         cnt_q   <= FirstAddr;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wipe_we = 1'b0;
      unique case (state_q)
         RfWipeReady: begin
            if (wipe_req_i) begin
               state_d = RfWipeActive;
               cnt_d   = FirstAddr;
            end
         end
         RfWipeActive: begin
            wipe_we = 1'b1;
            // The last register is written this cycle; park the counter at 1
            // so it never wraps through 0.
            if (cnt_q == LastAddr) begin
               state_d = RfWipeReady;
               cnt_d   = FirstAddr;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = RfWipeReady;
            cnt_d   = FirstAddr;
         end
      endcase
   end

   assign busy_o    = (state_q == RfWipeActive);
   assign wipe_addr = cnt_q;

endmodule

// File: rtl/ibex_register_file_mp.sv
// ibex_register_file_mp: flip-flop register file with parametrised read and
// write port counts, optional write-to-read bypass and a sequential secure
// wipe (one register per cycle, data supplied by the caller).
// Register 0 has no storage and always reads WordZeroVal.
// Optional build macro: IBEX_RF_WE_CHECK_EN enables the write-enable decode
// integrity check driving err_o; without it err_o is tied low.
// Ports:
//   clk_i        in   clock
//   rst_ni       in   synchronous active-low reset
//   raddr_i      in   NumReadPorts x 5 read addresses, port 0 in LSBs
//   rdata_o      out  NumReadPorts x DataWidth read data (combinational)
//   waddr_i      in   NumWritePorts x 5 write addresses
//   wdata_i      in   NumWritePorts x DataWidth write data
//   we_i         in   per-port write enables
//   wipe_req_i   in   single-cycle wipe start request
//   wipe_data_i  in   data written during the wipe
//   busy_o       out  wipe in progress
//   err_o        out  sticky write-enable integrity error
module ibex_register_file_mp
   import ibex_pkg::*;
#(
   parameter bit                   RV32E         = 1'b0,
   parameter int unsigned          DataWidth     = 32,
   parameter int unsigned          NumReadPorts  = 3,
   parameter int unsigned          NumWritePorts = 2,
   parameter bit                   WriteBypass   = 1'b0,
   parameter logic [DataWidth-1:0] WordZeroVal   = '0
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NumReadPorts*5-1:0]         raddr_i,
   output logic [NumReadPorts*DataWidth-1:0] rdata_o,
   input  logic [NumWritePorts*5-1:0]        waddr_i,
   input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
   input  logic [NumWritePorts-1:0]          we_i,
   input  logic                              wipe_req_i,
   input  logic [DataWidth-1:0]              wipe_data_i,
   output logic                              busy_o,
   output logic                              err_o
);

   localparam int unsigned AddrWidth = RV32E ? 4 : 5;
   localparam int unsigned NumWords  = 2 ** AddrWidth;

   if (NumReadPorts == 0 || NumReadPorts > RfMaxReadPorts) begin : gen_bad_read_ports
      $error("NumReadPorts must be in 1..%0d", RfMaxReadPorts);
   end
   if (NumWritePorts == 0 || NumWritePorts > RfMaxWritePorts) begin : gen_bad_write_ports
      $error("NumWritePorts must be in 1..%0d", RfMaxWritePorts);
   end

   logic                 wipe_we;
   logic [AddrWidth-1:0] wipe_addr;

   ibex_register_file_wipe_ctrl #(
      .AddrWidth (AddrWidth)
   ) u_wipe_ctrl (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .wipe_req_i (wipe_req_i),
      .busy_o     (busy_o),
      .wipe_we    (wipe_we),
      .wipe_addr  (wipe_addr)
   );

   // Per-port one-hot write decode. Register 0 has no entry, so a write to
   // address 0 (or an RV32E address with bit 4 set) decodes to all zeros.
   logic [NumWritePorts-1:0]                waddr_ok;
   logic [NumWritePorts-1:0][NumWords-1:1]  we_dec;

   always_comb begin
      for (int p = 0; p < NumWritePorts; p++) begin
         waddr_ok[p] = !(RV32E && waddr_i[p*5+4]);
         for (int w = 1; w < NumWords; w++) begin
            we_dec[p][w] = we_i[p] && waddr_ok[p] &&
                           (waddr_i[p*5 +: AddrWidth] == AddrWidth'(w));
         end
      end
   end

   // Merge wipe and port writes. The wipe owns every register while active;
   // otherwise the highest-index port wins a same-address conflict.
   logic                 reg_we    [1:NumWords-1];
   logic [DataWidth-1:0] reg_wdata [1:NumWords-1];

   always_comb begin
      for (int w = 1; w < NumWords; w++) begin
         reg_we[w]    = 1'b0;
         reg_wdata[w] = wipe_data_i;
         if (wipe_we) begin
            reg_we[w] = (wipe_addr == AddrWidth'(w));
         end else begin
            for (int p = 0; p < NumWritePorts; p++) begin
               if (we_dec[p][w]) begin
                  reg_we[w]    = 1'b1;
                  reg_wdata[w] = wdata_i[p*DataWidth +: DataWidth];
               end
            end
         end
      end
   end

   logic [DataWidth-1:0] rf_q [1:NumWords-1];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int w = 1; w < NumWords; w++) begin
            rf_q[w] <= WordZeroVal;
         end
      end else begin
         for (int w = 1; w < NumWords; w++) begin
            if (reg_we[w]) begin
               rf_q[w] <= reg_wdata[w];
            end
         end
      end
   end

   // Full view including the constant R0 so reads can index directly.
   logic [DataWidth-1:0] rf_all [NumWords];

   always_comb begin
      rf_all[0] = WordZeroVal;
      for (int w = 1; w < NumWords; w++) begin
         rf_all[w] = rf_q[w];
      end
   end

   for (genvar r = 0; r < NumReadPorts; r++) begin : gen_read
      logic [4:0]           ra;
      logic                 ra_ok;
      logic [DataWidth-1:0] rd;

      assign ra    = raddr_i[r*5 +: 5];
      // Reads are blanked during a wipe so no half-wiped state leaks out.
      assign ra_ok = !busy_o && !(RV32E && ra[4]);

      always_comb begin
         rd = WordZeroVal;
         if (ra_ok) begin
            rd = rf_all[ra[AddrWidth-1:0]];
            if (WriteBypass && (ra != 5'd0)) begin
               for (int p = 0; p < NumWritePorts; p++) begin
                  if (we_i[p] && (waddr_i[p*5 +: 5] == ra)) begin
                     rd = wdata_i[p*DataWidth +: DataWidth];
                  end
               end
            end
         end
      end

      assign rdata_o[r*DataWidth +: DataWidth] = rd;
   end

`ifdef IBEX_RF_WE_CHECK_EN
   // Each port's decode vector is cross-checked against a separate decode of
   // its address: it must be one-hot for an enabled in-range nonzero write,
   // empty when disabled, and never have a bit set for a different address.
   logic [NumWritePorts-1:0] we_chk_fail;
   logic                     err_q;

   for (genvar p = 0; p < NumWritePorts; p++) begin : gen_we_chk
      logic [NumWords-1:1] addr_dec;
      logic                addr_nz;

      always_comb begin
         for (int w = 1; w < NumWords; w++) begin
            addr_dec[w] = (waddr_i[p*5 +: AddrWidth] == AddrWidth'(w));
         end
      end

      assign addr_nz = waddr_ok[p] && (waddr_i[p*5 +: AddrWidth] != '0);

      assign we_chk_fail[p] = (we_i[p] && addr_nz && !$onehot(we_dec[p])) ||
                              (!we_i[p] && (|we_dec[p])) ||
                              (|(we_dec[p] & ~addr_dec));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (|we_chk_fail) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule
